power_frame_accum: RTL and testbench

- Downstream consumer of the 4-lane power pipeline outputs: col_1/col_2 power rows, their 11-bit indices and the output-valid strobe.
- Integrates per-bin power over 2^FRAMES_LOG2 frames into two accumulator banks, one per column.
- After the last frame, streams the accumulated rows out with a valid/ready handshake, then re-arms for the next integration period.

---
 rtl/power_frame_accum.sv | 124 ++++++++++++
 tb/tb_power_frame_accum.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/power_frame_accum.sv
// power_frame_accum: integrates 4-lane power rows over 2^FRAMES_LOG2 frames into two banks, then streams them out.
// Define ACC_SAT_EN to make lane adds saturate instead of wrapping.
module power_frame_accum #(
  parameter int DATA_WIDTH  = 53,
  parameter int ACC_WIDTH   = 64,
  parameter int ADDR_WIDTH  = 11,
  parameter int FRAMES_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [ADDR_WIDTH-1:0]   in_index_col1,
  input  logic [ADDR_WIDTH-1:0]   in_index_col2,
  input  logic [4*DATA_WIDTH-1:0] in_col1,
  input  logic [4*DATA_WIDTH-1:0] in_col2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_index,
  output logic [4*ACC_WIDTH-1:0]  out_col1,
  output logic [4*ACC_WIDTH-1:0]  out_col2,
  output logic                    out_last,
  output logic                    busy,
  output logic                    drop_err
);
  localparam logic [FRAMES_LOG2-1:0] FRAME_ONE = 1;
  localparam logic [ADDR_WIDTH:0]    PTR_ONE   = 1;
  typedef enum logic [1:0] {ACC, DRAIN, DUMP} state_t;
  state_t state, state_nx;
  logic [FRAMES_LOG2-1:0] frame_cnt;
  logic drain_cnt, rd_valid, accept, adv, done;
  logic [ADDR_WIDTH:0] ptr;
  logic [ADDR_WIDTH-1:0] rd_index;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACC;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ACC:     state_nx = (accept && in_last && &frame_cnt) ? DRAIN : ACC;
      DRAIN:   state_nx = drain_cnt ? DUMP : DRAIN;
      DUMP:    state_nx = done ? ACC : DUMP;
      default: state_nx = ACC;
    endcase
  end
  always_comb begin
    busy     = state != ACC;
    accept   = in_valid && state == ACC;
    adv      = !out_valid || out_ready;
    out_last = out_valid && &out_index;
    done     = out_valid && out_ready && out_last;
  end
  // Dump runs as a read stage (rd_*) feeding the output skid stage; both hold while stalled.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_cnt <= '0;
      drain_cnt <= 1'b0;
      ptr       <= '0;
      rd_valid  <= 1'b0;
      rd_index  <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      drop_err  <= 1'b0;
    end else begin
      drop_err  <= drop_err | (in_valid && busy);
      drain_cnt <= state == DRAIN && !drain_cnt;
      if (accept && in_last) frame_cnt <= frame_cnt + FRAME_ONE;
      if (state == DUMP && adv) begin
        rd_valid  <= !ptr[ADDR_WIDTH];
        rd_index  <= ptr[ADDR_WIDTH-1:0];
        out_valid <= rd_valid;
        out_index <= rd_index;
        if (!ptr[ADDR_WIDTH]) ptr <= ptr + PTR_ONE;
      end
      if (done) begin
        frame_cnt <= '0;
        ptr       <= '0;
        rd_valid  <= 1'b0;
        out_valid <= 1'b0;
      end
    end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [4*ACC_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [4*ACC_WIDTH-1:0] q, base, sum, s1_sum, out_q;
    logic [4*DATA_WIDTH-1:0] s0_data;
    logic [ADDR_WIDTH-1:0] s0_index, s1_index;
    logic s0_valid, s0_first, s1_valid;
    // The write of the previous sample lands on the same edge as this row's read, so forward it.
    assign base = (s1_valid && s1_index == s0_index) ? s1_sum : s0_first ? '0 : q;
    for (genvar k = 0; k < 4; k++) begin : g_lane
`ifdef ACC_SAT_EN
      logic [ACC_WIDTH:0] raw;
      assign raw = {1'b0, base[k*ACC_WIDTH +: ACC_WIDTH]} +
                   {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, s0_data[k*DATA_WIDTH +: DATA_WIDTH]};
      assign sum[k*ACC_WIDTH +: ACC_WIDTH] = raw[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : raw[ACC_WIDTH-1:0];
`else
      assign sum[k*ACC_WIDTH +: ACC_WIDTH] = base[k*ACC_WIDTH +: ACC_WIDTH] +
                   {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, s0_data[k*DATA_WIDTH +: DATA_WIDTH]};
`endif
    end
    always_ff @(posedge clk) begin
      s0_index <= b == 0 ? in_index_col1 : in_index_col2;
      s0_data  <= b == 0 ? in_col1 : in_col2;
      s0_first <= frame_cnt == '0;
      s1_index <= s0_index;
      s1_sum   <= sum;
      if (s0_valid) mem[s0_index] <= sum;
      if (state != DUMP) q <= mem[b == 0 ? in_index_col1 : in_index_col2];
      else if (adv) q <= mem[ptr[ADDR_WIDTH-1:0]];
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s0_valid <= 1'b0;
        s1_valid <= 1'b0;
        out_q    <= '0;
      end else begin
        s0_valid <= accept;
        s1_valid <= s0_valid;
        if (state == DUMP && adv) out_q <= q;
      end
  end
  assign out_col1 = g_bank[0].out_q;
  assign out_col2 = g_bank[1].out_q;
endmodule

// File: tb/tb_power_frame_accum.sv
// tb_power_frame_accum: vector table on a narrow instance plus directed and random periods on a full-width one.
module tb_power_frame_accum;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic vld, lst, ordy, ov, ol, busy, derr;
  logic [10:0] ix1, ix2, oi;
  logic [211:0] d1, d2;
  logic [255:0] o1, o2;
  power_frame_accum #(.DATA_WIDTH(53), .ACC_WIDTH(64), .ADDR_WIDTH(11), .FRAMES_LOG2(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_last(lst), .in_index_col1(ix1), .in_index_col2(ix2),
    .in_col1(d1), .in_col2(d2), .out_valid(ov), .out_ready(ordy), .out_index(oi), .out_col1(o1),
    .out_col2(o2), .out_last(ol), .busy(busy), .drop_err(derr));

  logic s_vld, s_lst, s_rdy, s_ov, s_ol, s_busy, s_derr;
  logic [1:0] s_i1, s_i2, s_oi;
  logic [31:0] s_d1, s_d2;
  logic [39:0] s_o1, s_o2;
  power_frame_accum #(.DATA_WIDTH(8), .ACC_WIDTH(10), .ADDR_WIDTH(2), .FRAMES_LOG2(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_vld), .in_last(s_lst), .in_index_col1(s_i1), .in_index_col2(s_i2),
    .in_col1(s_d1), .in_col2(s_d2), .out_valid(s_ov), .out_ready(s_rdy), .out_index(s_oi), .out_col1(s_o1),
    .out_col2(s_o2), .out_last(s_ol), .busy(s_busy), .drop_err(s_derr));

  int errors = 0, checks = 0, frame = 0;
  logic [63:0] m1 [2048][4];
  logic [63:0] m2 [2048][4];

  typedef struct { logic [7:0] v; int hits; logic [9:0] wrap_e; logic [9:0] sat_e; } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [599:0] got, input logic [599:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [52:0] r53();
    logic [63:0] x;
    x = {$urandom, $urandom};
    return x[52:0];
  endfunction

  function automatic logic [211:0] rpk();
    return {r53(), r53(), r53(), r53()};
  endfunction

  function automatic logic [255:0] rowv(input int c, input int n);
    logic [255:0] r;
    for (int k = 0; k < 4; k++) r[k*64 +: 64] = c == 1 ? m1[n][k] : m2[n][k];
    return r;
  endfunction

  // Reference: first frame of a period replaces the row, later frames add every sample modulo 2^64.
  task automatic send(input logic [10:0] a1, input logic [10:0] a2, input logic [211:0] p1,
                      input logic [211:0] p2, input logic last);
    vld = 1'b1; lst = last; ix1 = a1; ix2 = a2; d1 = p1; d2 = p2;
    for (int k = 0; k < 4; k++) begin
      m1[a1][k] = (frame == 0 ? 64'd0 : m1[a1][k]) + 64'(p1[k*53 +: 53]);
      m2[a2][k] = (frame == 0 ? 64'd0 : m2[a2][k]) + 64'(p2[k*53 +: 53]);
    end
    @(posedge clk); #1;
    vld = 1'b0; lst = 1'b0;
    if (last) frame = (frame + 1) % 4;
  endtask

  task automatic sweep(input logic [52:0] val, input bit rnd);
    for (int r = 0; r < 2048; r++)
      send(11'(r), 11'(2047 - r), rnd ? rpk() : {4{val}}, rnd ? rpk() : {4{val}}, r == 2047);
  endtask

  task automatic dump(input int mode, input string tag);
    int n = 0, t = 0, budget = 20000;
    logic held = 1'b0;
    logic [522:0] hv;
    while (n < 2048 && budget > 0) begin
      if (held) chk({tag, " hold"}, {ov, oi, o1, o2}, {1'b1, hv});
      ordy = mode == 0 ? 1'b1 : mode == 1 ? (t % 4 == 0 || t % 4 == 3) : 1'($urandom_range(0, 1));
      t++;
      held = 1'b0;
      if (ov) begin
        if (ordy) begin
          chk($sformatf("%s row%0d", tag, n), {oi, o1, o2, ol}, {11'(n), rowv(1, n), rowv(2, n), n == 2047});
          n++;
        end else begin
          held = 1'b1;
          hv = {oi, o1, o2};
        end
      end
      @(posedge clk); #1;
      budget--;
    end
    chk({tag, " rows"}, 32'(n), 32'd2048);
    chk({tag, " idle after"}, {busy, ov, ol}, 3'b000);
    ordy = 1'b0;
  endtask

  task automatic send_s(input logic [1:0] a1, input logic [1:0] a2, input logic [7:0] v1,
                        input logic [7:0] v2, input logic last);
    s_vld = 1'b1; s_lst = last; s_i1 = a1; s_i2 = a2; s_d1 = {4{v1}}; s_d2 = {4{v2}};
    @(posedge clk); #1;
    s_vld = 1'b0; s_lst = 1'b0;
  endtask

  task automatic dump_s(input logic [9:0] e, input int i);
    int n = 0, b = 0;
    s_rdy = 1'b1;
    while (n < 4 && b < 50) begin
      if (s_ov) begin
        chk($sformatf("tbl%0d row%0d", i, n), {s_oi, s_o1, s_o2, s_ol},
            {2'(n), n == 1 ? {4{e}} : 40'd0, n == 2 ? {4{e}} : 40'd0, n == 3});
        n++;
      end
      @(posedge clk); #1;
      b++;
    end
    chk($sformatf("tbl%0d rows", i), 32'(n), 32'd4);
    s_rdy = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [10:0] pa1, pa2;
    logic [9:0] e;
    tbl[0] = '{8'd1,   1, 10'd4,    10'd4};
    tbl[1] = '{8'd3,   2, 10'd21,   10'd21};
    tbl[2] = '{8'd255, 1, 10'd1020, 10'd1020};
    tbl[3] = '{8'd255, 2, 10'd761,  10'd1023};
    tbl[4] = '{8'd100, 0, 10'd100,  10'd100};
    tbl[5] = '{8'd200, 3, 10'd976,  10'd1023};
    tbl[6] = '{8'd0,   3, 10'd0,    10'd0};
    vld = 0; lst = 0; ix1 = 0; ix2 = 0; d1 = 0; d2 = 0; ordy = 0;
    s_vld = 0; s_lst = 0; s_i1 = 0; s_i2 = 0; s_d1 = 0; s_d2 = 0; s_rdy = 0;
    pa1 = 0; pa2 = 0;
    #12;
    chk("reset u0", {ov, oi, o1, o2, ol, busy, derr}, '0);
    chk("reset u1", {s_ov, s_oi, s_o1, s_o2, s_ol, s_busy, s_derr}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      for (int r = 0; r < 4; r++)
        send_s(2'(r), 2'(r), r == 1 ? tbl[i].v : 8'd0, r == 2 ? tbl[i].v : 8'd0, r == 3);
      for (int f = 1; f < 4; f++) begin
        for (int h = 0; h < tbl[i].hits; h++) send_s(2'd1, 2'd2, tbl[i].v, tbl[i].v, 1'b0);
        send_s(2'd3, 2'd3, 8'd0, 8'd0, 1'b1);
      end
`ifdef ACC_SAT_EN
      e = tbl[i].sat_e;
`else
      e = tbl[i].wrap_e;
`endif
      dump_s(e, i);
    end

    for (int f = 0; f < 4; f++) sweep(53'd1, 1'b0);
    chk("drain busy", {busy, ov}, 2'b10);
    t = 0;
    while (!ov && t < 20) begin @(posedge clk); #1; t++; end
    chk("dump latency", 32'(t), 32'd4);
    dump(0, "ones");

    sweep(53'd0, 1'b0);
    send(11'd5, 11'd5, {4{53'd999}}, {4{53'd999}}, 1'b1);
    send(11'd0, 11'd0, '0, '0, 1'b1);
    send(11'd0, 11'd0, '0, '0, 1'b1);
    dump(0, "prior");
    sweep(53'd100, 1'b0);
    send(11'd7, 11'd7, {4{53'd1}}, {4{53'd1}}, 1'b0);
    send(11'd7, 11'd7, {4{53'd2}}, {4{53'd2}}, 1'b0);
    send(11'd7, 11'd7, {4{53'd3}}, {4{53'd3}}, 1'b0);
    send(11'd5, 11'd5, '0, '0, 1'b1);
    send(11'd5, 11'd5, '0, '0, 1'b1);
    send(11'd5, 11'd5, '0, '0, 1'b1);
    chk("drop_err clear", 32'(derr), 32'd0);
    vld = 1'b1; lst = 1'b1; ix1 = 11'd5; ix2 = 11'd7; d1 = '1; d2 = '1;
    @(posedge clk); #1;
    vld = 1'b0; lst = 1'b0;
    chk("drop_err set", 32'(derr), 32'd1);
    dump(1, "stall");
    chk("drop_err sticky", 32'(derr), 32'd1);

    sweep(53'd0, 1'b1);
    for (int f = 1; f < 4; f++) begin
      for (int j = 0; j < 150; j++) begin
        if ($urandom_range(0, 4) == 0) begin
          lst = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          lst = 1'b0;
        end else begin
          if ($urandom_range(0, 2) != 0) begin
            pa1 = 11'($urandom_range(0, 2047));
            pa2 = 11'($urandom_range(0, 2047));
          end
          send(pa1, pa2, rpk(), rpk(), 1'b0);
        end
      end
      send(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), rpk(), rpk(), 1'b1);
    end
    dump(2, "random");

    sweep(53'd2, 1'b0);
    for (int f = 1; f < 4; f++) send(11'd9, 11'd9, {4{53'd1}}, {4{53'd1}}, 1'b1);
    ordy = 1'b1;
    t = 0;
    while (!(ov && oi == 11'd100) && t < 3000) begin @(posedge clk); #1; t++; end
    chk("reach row 100", {ov, oi}, {1'b1, 11'd100});
    rst_n = 1'b0;
    #1;
    chk("async reset mid-dump", {ov, oi, o1, o2, ol, busy, derr}, '0);
    #2;
    rst_n = 1'b1;
    ordy = 1'b0;
    frame = 0;
    @(posedge clk); #1;
    sweep(53'd0, 1'b1);
    for (int f = 1; f < 4; f++) send(11'($urandom_range(0, 2047)), 11'd3, rpk(), rpk(), 1'b1);
    dump(0, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
